// File: rtl/ex_stage_pkg.sv
// Shared encodings and widths for the MIPS execute stage and its divider.
package ex_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 8;
  localparam int ALUSEL_W   = 3;
  localparam int STALL_W    = 6;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  localparam logic [ALUSEL_W-1:0] SEL_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] SEL_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] SEL_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] SEL_MOVE  = 3'b011;
  localparam logic [ALUSEL_W-1:0] SEL_ARITH = 3'b100;
  localparam logic [ALUSEL_W-1:0] SEL_MUL   = 3'b101;

  localparam logic [ALUOP_W-1:0] OP_NOP   = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] OP_AND   = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] OP_OR    = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] OP_XOR   = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] OP_NOR   = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] OP_SLL   = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] OP_SRL   = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] OP_SRA   = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [ALUOP_W-1:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [ALUOP_W-1:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [ALUOP_W-1:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [ALUOP_W-1:0] OP_SLT   = 8'b0010_1010;
  localparam logic [ALUOP_W-1:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [ALUOP_W-1:0] OP_ADD   = 8'b0010_0000;
  localparam logic [ALUOP_W-1:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [ALUOP_W-1:0] OP_SUB   = 8'b0010_0010;
  localparam logic [ALUOP_W-1:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [ALUOP_W-1:0] OP_MULT  = 8'b0001_1000;
  localparam logic [ALUOP_W-1:0] OP_MULTU = 8'b0001_1001;
  localparam logic [ALUOP_W-1:0] OP_MUL   = 8'b1010_1001;
  localparam logic [ALUOP_W-1:0] OP_DIV   = 8'b0001_1010;
  localparam logic [ALUOP_W-1:0] OP_DIVU  = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } div_state_e;

  // Two's-complement overflow of a + b from the sign bits alone.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
interface ex_stage_if import ex_stage_pkg::*; #(parameter int WIDTH = DATA_W);

  logic [ALUOP_W-1:0]    aluop_i;
  logic [ALUSEL_W-1:0]   alusel_i;
  logic [WIDTH-1:0]      data1_i;
  logic [WIDTH-1:0]      data2_i;
  logic [REG_ADDR_W-1:0] waddr_i;
  logic                  we_i;
  logic [WIDTH-1:0]      hi_i;
  logic [WIDTH-1:0]      lo_i;
  logic [STALL_W-1:0]    stall;

  logic [REG_ADDR_W-1:0] waddr_o;
  logic                  we_o;
  logic [WIDTH-1:0]      wdata_o;
  logic                  whilo_o;
  logic [WIDTH-1:0]      hi_o;
  logic [WIDTH-1:0]      lo_o;
  logic                  stallreq_o;
  logic                  ovf_o;

  modport master (
    output aluop_i, alusel_i, data1_i, data2_i, waddr_i, we_i, hi_i, lo_i, stall,
    input  waddr_o, we_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o, ovf_o
  );

  modport slave (
    input  aluop_i, alusel_i, data1_i, data2_i, waddr_i, we_i, hi_i, lo_i, stall,
    output waddr_o, we_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o, ovf_o
  );

endinterface

// File: rtl/ex_stage_div_unit.sv
// Iterative restoring divider, one quotient bit per cycle, WIDTH iterations.
// state    | meaning
// DIV_IDLE | waiting for a DIV/DIVU; latches magnitudes and signs on start
// DIV_ZERO | divisor was zero; result forced to 0
// DIV_ON   | shift-subtract iteration, r_cnt counts 0..WIDTH-1
// DIV_END  | result valid; held while downstream is stalled
module div_unit import ex_stage_pkg::*; #(
  parameter int WIDTH = DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_opdata1,
  input  logic [WIDTH-1:0]   i_opdata2,
  input  logic               i_hold,
  output logic               o_ready,
  output logic               o_busy,
  output logic [2*WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH:0]   r_work;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_ready;
  logic [2*WIDTH-1:0] r_result;

  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH:0]   w_step;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;

  // Partial remainder lives in r_work[2W:W] (33 bits), so large unsigned divisors compare correctly.
  assign w_diff = r_work[2*WIDTH:WIDTH] - {1'b0, r_divisor};
  assign w_step = w_diff[WIDTH] ? {r_work[2*WIDTH-1:0], 1'b0}
                                : {w_diff[WIDTH-1:0], r_work[WIDTH-1:0], 1'b1};
  assign w_quo  = w_step[WIDTH-1:0];
  assign w_rem  = w_step[2*WIDTH:WIDTH+1];

  assign w_abs1 = (i_signed && i_opdata1[WIDTH-1]) ? -i_opdata1 : i_opdata1;
  assign w_abs2 = (i_signed && i_opdata2[WIDTH-1]) ? -i_opdata2 : i_opdata2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= DIV_IDLE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_ready   <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (i_start) begin
            if (i_opdata2 == '0) begin
              r_state <= DIV_ZERO;
            end else begin
              r_state   <= DIV_ON;
              r_cnt     <= '0;
              r_work    <= {{WIDTH{1'b0}}, w_abs1, 1'b0};
              r_divisor <= w_abs2;
              r_neg_q   <= i_signed && (i_opdata1[WIDTH-1] ^ i_opdata2[WIDTH-1]);
              r_neg_r   <= i_signed && i_opdata1[WIDTH-1];
            end
          end
        end
        DIV_ZERO: begin
          r_state  <= DIV_END;
          r_result <= '0;
          r_ready  <= 1'b1;
        end
        DIV_ON: begin
          r_work <= w_step;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state  <= DIV_END;
            r_ready  <= 1'b1;
            r_result <= {(r_neg_r ? -w_rem : w_rem), (r_neg_q ? -w_quo : w_quo)};
          end
        end
        DIV_END: begin
          if (!i_hold) begin
            r_state <= DIV_IDLE;
            r_ready <= 1'b0;
          end
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  assign o_busy   = ((r_state == DIV_IDLE) && i_start) || (r_state == DIV_ZERO) || (r_state == DIV_ON);
  assign o_ready  = r_ready;
  assign o_result = r_result;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU result, HI/LO writes and the iterative divider.
// Define EX_OVF_TRAP_EN to flag signed ADD/SUB overflow and suppress the GPR write.
module ex_stage import ex_stage_pkg::*; #(
  parameter int WIDTH = DATA_W
) (
  input  logic     clk,
  input  logic     rst,
  ex_stage_if.slave bus
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [SH_W-1:0]    w_shamt;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_sub;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic [WIDTH-1:0]   w_wdata;
  logic               w_whilo;
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_lo;
  logic               w_ovf;
  logic               w_div_start;
  logic               w_div_ready;
  logic               w_div_busy;
  logic [2*WIDTH-1:0] w_div_result;
  logic               w_unused_stall;

  assign w_a      = bus.data1_i;
  assign w_b      = bus.data2_i;
  assign w_shamt  = w_a[SH_W-1:0];
  assign w_sum    = w_a + w_b;
  assign w_sub    = w_a - w_b;
  assign w_prod_s = {{WIDTH{w_a[WIDTH-1]}}, w_a} * {{WIDTH{w_b[WIDTH-1]}}, w_b};
  assign w_prod_u = {{WIDTH{1'b0}}, w_a} * {{WIDTH{1'b0}}, w_b};

  assign w_div_start    = (bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU);
  assign w_unused_stall = ^{bus.stall[5:4], bus.stall[2:0]};

  div_unit #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_div_start),
    .i_signed  (bus.aluop_i == OP_DIV),
    .i_opdata1 (w_a),
    .i_opdata2 (w_b),
    .i_hold    (bus.stall[3]),
    .o_ready   (w_div_ready),
    .o_busy    (w_div_busy),
    .o_result  (w_div_result)
  );

  always_comb begin
    w_wdata = '0;
    case (bus.alusel_i)
      SEL_LOGIC: begin
        case (bus.aluop_i)
          OP_AND:  w_wdata = w_a & w_b;
          OP_OR:   w_wdata = w_a | w_b;
          OP_XOR:  w_wdata = w_a ^ w_b;
          OP_NOR:  w_wdata = ~(w_a | w_b);
          default: w_wdata = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (bus.aluop_i)
          OP_SLL:  w_wdata = w_b << w_shamt;
          OP_SRL:  w_wdata = w_b >> w_shamt;
          OP_SRA:  w_wdata = $unsigned($signed(w_b) >>> w_shamt);
          default: w_wdata = '0;
        endcase
      end
      SEL_ARITH: begin
        case (bus.aluop_i)
          OP_ADD, OP_ADDU: w_wdata = w_sum;
          OP_SUB, OP_SUBU: w_wdata = w_sub;
          OP_SLT:  w_wdata = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
          OP_SLTU: w_wdata = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
          default: w_wdata = '0;
        endcase
      end
      SEL_MOVE: begin
        case (bus.aluop_i)
          OP_MFHI: w_wdata = bus.hi_i;
          OP_MFLO: w_wdata = bus.lo_i;
          default: w_wdata = '0;
        endcase
      end
      SEL_MUL: w_wdata = w_prod_s[WIDTH-1:0];
      default: w_wdata = '0;
    endcase
  end

  always_comb begin
    w_whilo = 1'b0;
    w_hi    = '0;
    w_lo    = '0;
    case (bus.aluop_i)
      OP_MULT: begin
        w_whilo     = 1'b1;
        {w_hi, w_lo} = w_prod_s;
      end
      OP_MULTU: begin
        w_whilo     = 1'b1;
        {w_hi, w_lo} = w_prod_u;
      end
      OP_MTHI: begin
        w_whilo = 1'b1;
        w_hi    = w_a;
        w_lo    = bus.lo_i;
      end
      OP_MTLO: begin
        w_whilo = 1'b1;
        w_hi    = bus.hi_i;
        w_lo    = w_a;
      end
      OP_DIV, OP_DIVU: begin
        if (w_div_ready) begin
          w_whilo     = 1'b1;
          {w_hi, w_lo} = w_div_result;
        end
      end
      default: w_whilo = 1'b0;
    endcase
  end

`ifdef EX_OVF_TRAP_EN
  always_comb begin
    w_ovf = 1'b0;
    if (bus.alusel_i == SEL_ARITH) begin
      if (bus.aluop_i == OP_ADD)
        w_ovf = add_ovf(w_a[WIDTH-1], w_b[WIDTH-1], w_sum[WIDTH-1]);
      else if (bus.aluop_i == OP_SUB)
        w_ovf = add_ovf(w_a[WIDTH-1], ~w_b[WIDTH-1], w_sub[WIDTH-1]);
    end
  end
`else
  assign w_ovf = 1'b0;
`endif

  // Everything reads as zero while reset is held, regardless of the inputs.
  assign bus.waddr_o    = rst ? bus.waddr_i : '0;
  assign bus.we_o       = rst & bus.we_i & ~w_ovf;
  assign bus.wdata_o    = rst ? w_wdata : ZERO_WORD;
  assign bus.whilo_o    = rst & w_whilo;
  assign bus.hi_o       = rst ? w_hi : ZERO_WORD;
  assign bus.lo_o       = rst ? w_lo : ZERO_WORD;
  assign bus.stallreq_o = rst & w_div_busy;
  assign bus.ovf_o      = rst & w_ovf;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its aluop, alusel, operand, waddr and we outputs.
- Computes the GPR write result (logic, shift, arithmetic, move, mul) and HI/LO writes.
- Contains an iterative 32-cycle divider FSM that raises a stall request to the stall controller until the quotient and remainder are ready.
- Outputs feed the EX/MEM register.

Parameters:
- WIDTH, 32, datapath width. Divider iteration count equals WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- aluop_i  in  `AluOpBus  operation subtype.
- alusel_i  in  `AluSelBus  operation class.
- data1_i  in  `RegDataBus  operand 1; for shifts, bits [4:0] are the shift amount.
- data2_i  in  `RegDataBus  operand 2; for shifts, the value being shifted.
- waddr_i  in  `RegAddrBus  destination register.
- we_i  in  1  GPR write enable.
- hi_i  in  `RegDataBus  current HI, already forwarded from MEM/WB.
- lo_i  in  `RegDataBus  current LO, already forwarded from MEM/WB.
- stall  in  6  global stall vector.
- waddr_o  out  `RegAddrBus  destination register passed through.
- we_o  out  1  GPR write enable.
- wdata_o  out  `RegDataBus  GPR write data.
- whilo_o  out  1  HI/LO write enable.
- hi_o  out  `RegDataBus  HI write data.
- lo_o  out  `RegDataBus  LO write data.
- stallreq_o  out  1  stall request to the controller.
- ovf_o  out  1  arithmetic overflow flag.

Behaviour:
- Outputs are combinational from the inputs plus divider state; they settle in the same cycle.
- rst low: FSM to IDLE, counter 0, divider registers 0. All outputs read 0 / `Disable / `ZeroWord while rst is low.
- Result selection by alusel_i:
  - LOGIC: AND, OR, XOR, NOR.
  - SHIFT: SLL, SRL, SRA of data2_i by data1_i[4:0].
  - ARITH:
    - ADD/ADDU/SUB/SUBU are mod 2^32.
    - SLT is signed compare; SLTU is unsigned compare; result is 1 or 0.
  - MOVE: MFHI gives hi_i; MFLO gives lo_i.
  - MUL: low 32 bits of the signed 64-bit product.
  - NOP: 0.
- HI/LO writes:
  - MULT/MULTU: whilo_o=1, {hi_o,lo_o} = 64-bit signed/unsigned product.
  - MTHI: hi_o=data1_i, lo_o=lo_i.
  - MTLO: lo_o=data1_i, hi_o=hi_i.
  - DIV/DIVU: LO=quotient, HI=remainder, whilo_o=1 only in END.
  - All other ops: whilo_o=0.
- Divider FSM states: IDLE, DIVZERO, ON, END.
  - IDLE: on aluop DIV/DIVU, stallreq_o=1. If data2_i==0, next state is DIVZERO; else latch |dividend| and |divisor| (raw values for DIVU), record signs, next state ON.
  - DIVZERO: stallreq_o=1; result forced HI=LO=0; next state END.
  - ON: restoring shift-subtract, one bit per cycle, stallreq_o=1. After the 32nd iteration (counter==31), next state END.
  - END: stallreq_o=0, result valid.
    - Signed fixup: quotient negated if operand signs differ; remainder takes the dividend's sign.
    - Stays in END while stall[3]=1 (downstream stall); otherwise goes to IDLE.
- DIV latency: stallreq_o high for 33 cycles (1 IDLE + 32 ON), or 2 cycles when dividing by zero; the result is committed in the following cycle.
- Operands are held stable by ID/EX because stallreq stalls stages 0-3; ID/EX inserts no bubble during this.
- rst low in any state: immediate return to IDLE and stallreq_o=0. The partial result is discarded.
- we_o=we_i except when overflow suppression applies (see Optional Feature).

Optional Feature:
- Macro EX_OVF_TRAP_EN.
- Defined: ADD/SUB signed overflow drives ovf_o=1 and we_o=0.
- Undefined: ovf_o tied 0 and we_o=we_i always.

Decomposition:
- Shared package/define.vh: aluop/alusel encodings, `ZeroWord, `Disable, divider state encodings, `DivIters.
- One sub-module: div_unit. It owns the FSM, the counter and the 65-bit working register, with ports start/signed/opdata1/opdata2/ready/result.

Test Plan:
- SRA, data1=4, data2=0x80000010 -> wdata_o=0xF8000001, stallreq_o=0.
- MULT, data1=0xFFFFFFFE, data2=3 -> whilo_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA.
- DIV, data1=-7 (0xFFFFFFF9), data2=2 -> stallreq high 33 cycles, then lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIVU, data2=0 -> stallreq 2 cycles; END gives hi_o=lo_o=0, whilo_o=1.
- DIV in progress, rst low at iteration 10 -> next cycle IDLE, stallreq_o=0, whilo_o=0.
- ADD 0x7FFFFFFF+1 with EX_OVF_TRAP_EN -> ovf_o=1, we_o=0. Without the macro -> wdata_o=0x80000000, we_o=1.
